// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// State encoding, reset PC default and instruction/PC step sizes.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DRAIN,
        HOLD
    } fetch_state_e;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          PC_STEP          = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the imem request/response port and the decode-side handshake.
// master = fetch controller, slave = memory plus decode.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 64
) ();
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc_plus_4;
    logic [ADDR_W-1:0]  out_pre_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        output out_pc,
        output out_instr,
        output out_pc_plus_4,
        output out_pre_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  out_pc_plus_4,
        input  out_pre_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC select: aligned redirect, then sequential pc+4, else hold.
// Also exports pc+4 (wraps modulo 2^ADDR_W).
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_q,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] pc_plus_4
);

    logic [ADDR_W-1:0] redirect_aligned;

    assign pc_plus_4        = pc_q + ADDR_W'(PC_STEP);
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_valid:            pc_d = redirect_aligned;
            advance & ~redirect_valid: pc_d = pc_plus_4;
            default:                   pc_d = pc_q;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, single outstanding imem request, output reg.
// Define FETCH_CTRL_COMMIT_EN to add the commit_valid/pc/instr trace port.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_ctrl_if.master      bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_CTRL_COMMIT_EN
    ,
    output logic               commit_valid,
    output logic [ADDR_W-1:0]  commit_pc,
    output logic [INSTR_W-1:0] commit_instr
`endif
);

    fetch_state_e       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  pc_plus_4;
    logic [ADDR_W-1:0]  out_pc_q;
    logic [ADDR_W-1:0]  out_p4_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic               req_valid;
    logic               req_fire;
    logic               rsp_take;
    logic               out_valid;

    assign req_valid = rst_n & (state_q == REQ) & ~redirect_valid;
    assign req_fire  = req_valid & bus.imem_req_ready;
    assign rsp_take  = (state_q == WAIT) & bus.imem_rsp_valid
                     & ~redirect_valid;
    assign out_valid = (state_q == HOLD) & ~redirect_valid;

    fetch_pc_gen #(
        .ADDR_W(ADDR_W)
    ) u_pc_gen (
        .pc_q          (pc_q),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (rsp_take),
        .pc_d          (pc_d),
        .pc_plus_4     (pc_plus_4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            out_pc_q    <= '0;
            out_p4_q    <= '0;
            out_instr_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (rsp_take) begin
                out_pc_q    <= pc_q;
                out_p4_q    <= pc_plus_4;
                out_instr_q <= bus.imem_rsp_data;
            end
            case (state_q)
                REQ: begin
                    if (req_fire) state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid)
                        state_q <= redirect_valid ? REQ : HOLD;
                    else if (redirect_valid)
                        state_q <= DRAIN;
                end
                // Swallow the response still owed for the killed request.
                DRAIN: begin
                    if (bus.imem_rsp_valid) state_q <= REQ;
                end
                HOLD: begin
                    if (redirect_valid | bus.out_ready) state_q <= REQ;
                end
                default: state_q <= REQ;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.out_pc_plus_4  = out_p4_q;
    assign bus.out_pre_pc     = out_p4_q;

`ifdef FETCH_CTRL_COMMIT_EN
    assign commit_valid = out_valid & bus.out_ready;
    assign commit_pc    = out_pc_q;
    assign commit_instr = out_instr_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: one table row per clock cycle,
// plus a hand-written asynchronous reset sequence in the middle of WAIT.
module tb_fetch_ctrl;

    localparam logic [63:0] B   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] I0  = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h0010_0093;
    localparam logic [31:0] I2  = 32'h0020_0113;
    localparam logic [31:0] I3  = 32'h0030_0193;
    localparam logic [31:0] I4  = 32'h0040_0213;
    localparam logic [31:0] I5  = 32'h0050_0293;

    typedef struct {
        string       name;
        bit          rstn;
        bit          rdv;
        logic [63:0] rdpc;
        bit          rqr;
        bit          rsv;
        logic [31:0] rsd;
        bit          ordy;
        bit          e_rqv;
        logic [63:0] e_addr;
        bit          e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[$];

    fetch_ctrl_if #(.ADDR_W(64)) bus ();

`ifdef FETCH_CTRL_COMMIT_EN
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_instr;
`endif

    fetch_ctrl #(
        .ADDR_W  (64),
        .RESET_PC(B)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_CTRL_COMMIT_EN
        ,
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_instr  (commit_instr)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string       n,
        input bit          rdv,
        input logic [63:0] rdpc,
        input bit          rqr,
        input bit          rsv,
        input logic [31:0] rsd,
        input bit          ordy,
        input bit          erqv,
        input logic [63:0] eaddr,
        input bit          eov,
        input logic [63:0] epc,
        input logic [31:0] eins
    );
        vec_t v;
        v.name   = n;
        v.rstn   = 1'b1;
        v.rdv    = rdv;
        v.rdpc   = rdpc;
        v.rqr    = rqr;
        v.rsv    = rsv;
        v.rsd    = rsd;
        v.ordy   = ordy;
        v.e_rqv  = erqv;
        v.e_addr = eaddr;
        v.e_ov   = eov;
        v.e_pc   = epc;
        v.e_ins  = eins;
        return v;
    endfunction

    // Drive one cycle's inputs mid-cycle, then compare before the next edge.
    task automatic run(input vec_t v);
        logic bad;
        @(negedge clk);
        rst_n              = v.rstn;
        redirect_valid     = v.rdv;
        redirect_pc        = v.rdpc;
        bus.imem_req_ready = v.rqr;
        bus.imem_rsp_valid = v.rsv;
        bus.imem_rsp_data  = v.rsd;
        bus.out_ready      = v.ordy;
        #1;
        n_vec++;
        bad = (bus.imem_req_valid !== v.e_rqv)
            | (bus.imem_req_addr !== v.e_addr)
            | (bus.out_valid !== v.e_ov)
            | (bus.out_pc !== v.e_pc)
            | (bus.out_instr !== v.e_ins);
        if (v.e_ov)
            bad |= (bus.out_pc_plus_4 !== v.e_pc + 64'd4)
                 | (bus.out_pre_pc !== v.e_pc + 64'd4);
        if (!v.rstn)
            bad |= (bus.out_pc_plus_4 !== '0)
                 | (bus.out_pre_pc !== '0);
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got rqv=%0b addr=%h ov=%0b pc=%h ins=%h p4=%h pre=%h; want rqv=%0b addr=%h ov=%0b pc=%h ins=%h",
                     v.name, bus.imem_req_valid, bus.imem_req_addr,
                     bus.out_valid, bus.out_pc, bus.out_instr,
                     bus.out_pc_plus_4, bus.out_pre_pc,
                     v.e_rqv, v.e_addr, v.e_ov, v.e_pc, v.e_ins);
        end
    endtask

    initial begin
        vec_t v;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.out_ready      = 1'b0;

        // name, rdv, rdpc, rqr, rsv, rsd, ordy | rqv, addr, ov, pc, ins
        tbl.push_back(mk("req0", 0, 0, 1, 0, 0, 1, 1, B, 0, 0, 0));
        tbl.push_back(mk("rsp0", 0, 0, 1, 1, I0, 1, 0, B, 0, 0, 0));
        tbl.push_back(mk("out0", 0, 0, 1, 0, 0, 1, 0, B+4, 1, B, I0));
        tbl.push_back(mk("req1", 0, 0, 1, 0, 0, 1, 1, B+4, 0, B, I0));
        tbl.push_back(mk("rsp1", 0, 0, 1, 1, I1, 1, 0, B+4, 0, B, I0));
        tbl.push_back(mk("out1", 0, 0, 1, 0, 0, 1, 0, B+8, 1, B+4, I1));
        tbl.push_back(mk("req2", 0, 0, 1, 0, 0, 1, 1, B+8, 0, B+4, I1));
        tbl.push_back(mk("rsp2", 0, 0, 1, 1, I2, 1, 0, B+8, 0, B+4, I1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("stall", 0, 0, 1, 0, 0, 0,
                             0, B+12, 1, B+8, I2));
        tbl.push_back(mk("out2", 0, 0, 1, 0, 0, 1, 0, B+12, 1, B+8, I2));
        tbl.push_back(mk("req3", 0, 0, 1, 0, 0, 1, 1, B+12, 0, B+8, I2));
        tbl.push_back(mk("wait_redir", 1, B+'h100, 1, 0, 0, 1,
                         0, B+12, 0, B+8, I2));
        tbl.push_back(mk("drain0", 0, 0, 1, 0, 0, 1,
                         0, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("drain1", 0, 0, 1, 0, 0, 1,
                         0, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("drain_rsp", 0, 0, 1, 1, 32'hDEAD_BEEF, 1,
                         0, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("req_nrdy", 0, 0, 0, 0, 0, 1,
                         1, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("req4", 0, 0, 1, 0, 0, 1,
                         1, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("wait_redir2", 1, B+'h200, 1, 0, 0, 1,
                         0, B+'h100, 0, B+8, I2));
        tbl.push_back(mk("drain_redir", 1, B+'h300, 1, 0, 0, 1,
                         0, B+'h200, 0, B+8, I2));
        tbl.push_back(mk("drain_rsp2", 0, 0, 1, 1, 32'h0BAD_F00D, 1,
                         0, B+'h300, 0, B+8, I2));
        tbl.push_back(mk("req5", 0, 0, 1, 0, 0, 1,
                         1, B+'h300, 0, B+8, I2));
        tbl.push_back(mk("rsp5", 0, 0, 1, 1, I3, 1,
                         0, B+'h300, 0, B+8, I2));
        tbl.push_back(mk("hold_redir", 1, B+'h403, 1, 0, 0, 1,
                         0, B+'h304, 0, B+'h300, I3));
        tbl.push_back(mk("req_aligned", 0, 0, 0, 0, 0, 1,
                         1, B+'h400, 0, B+'h300, I3));
        tbl.push_back(mk("req_redir", 1, B+'h500, 1, 0, 0, 1,
                         0, B+'h400, 0, B+'h300, I3));
        tbl.push_back(mk("req7", 0, 0, 1, 0, 0, 1,
                         1, B+'h500, 0, B+'h300, I3));
        tbl.push_back(mk("wait_rsp_redir", 1, B+'h600, 1, 1,
                         32'hCAFE_BABE, 1, 0, B+'h500, 0, B+'h300, I3));
        tbl.push_back(mk("req8", 0, 0, 1, 0, 0, 1,
                         1, B+'h600, 0, B+'h300, I3));
        tbl.push_back(mk("wait_redir3", 1, B+'h700, 1, 0, 0, 1,
                         0, B+'h600, 0, B+'h300, I3));
        tbl.push_back(mk("drain_rsp_redir", 1, 64'hFFFF_FFFF_FFFF_FFFE,
                         1, 1, 32'h1234_5678, 1,
                         0, B+'h700, 0, B+'h300, I3));
        tbl.push_back(mk("req_top", 0, 0, 1, 0, 0, 1,
                         1, TOP, 0, B+'h300, I3));
        tbl.push_back(mk("rsp_top", 0, 0, 1, 1, I4, 1,
                         0, TOP, 0, B+'h300, I3));
        tbl.push_back(mk("out_top", 0, 0, 1, 0, 0, 1, 0, 0, 1, TOP, I4));
        tbl.push_back(mk("req_wrap", 0, 0, 1, 0, 0, 1, 1, 0, 0, TOP, I4));

        v = mk("reset", 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0);
        v.rstn = 1'b0;
        run(v);

        foreach (tbl[i]) run(tbl[i]);

        // Async reset while WAIT: clears outputs before any clock edge.
        v = mk("reset_mid_wait", 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 0);
        v.rstn = 1'b0;
        run(v);
        run(mk("rst_release", 0, 0, 1, 0, 0, 1, 1, B, 0, 0, 0));
        run(mk("rst_wait", 0, 0, 1, 0, 0, 1, 0, B, 0, 0, 0));
        run(mk("rst_rsp", 0, 0, 1, 1, I5, 1, 0, B, 0, 0, 0));
        run(mk("rst_out", 0, 0, 1, 0, 0, 1, 0, B+4, 1, B, I5));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch: owns the PC register and issues one-at-a-time requests to the instruction memory port.
- Holds the returned instruction in a single output register and presents it to decode through a valid/ready handshake.
- Handles redirects (branch/jump/trap) from execute, including killing in-flight responses.
- Sits between the memory interface and the combinational fetch/decode logic; supplies pc, instr, pc+4 and the predicted next pc.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- ADDR_W, 64, PC/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address (= pc_q).
- imem_rsp_valid  in  1  response valid, one per accepted request, ≥1 cycle after accept.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_pc  out  ADDR_W  pc of held instruction.
- out_instr  out  32  held instruction.
- out_pc_plus_4  out  ADDR_W  out_pc + 4.
- out_pre_pc  out  ADDR_W  predicted next pc (= out_pc + 4, static not-taken).

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, pc_q=RESET_PC.
  - out_valid=0; out_pc, out_instr, out_pc_plus_4, out_pre_pc = 0.
  - imem_req_valid=0 while in reset.
- At most one outstanding memory request.
- States:
  - REQ: imem_req_valid = !redirect_valid; imem_req_addr = pc_q.
    - Redirect → pc_q<=redirect_pc, stay REQ, no request issued.
    - Else req handshake → WAIT.
  - WAIT:
    - rsp_valid & !redirect → capture {pc_q, rsp_data} into output register, pc_q<=pc_q+4, → HOLD.
    - rsp_valid & redirect → discard response, pc_q<=redirect_pc, → REQ.
    - redirect only → pc_q<=redirect_pc, → DRAIN.
  - DRAIN:
    - Later redirects overwrite pc_q (latest wins).
    - rsp_valid → discard, → REQ.
    - rsp_valid and redirect in the same cycle → pc_q<=redirect_pc, → REQ.
  - HOLD: out_valid = !redirect_valid (combinational kill).
    - Redirect → instruction dropped, pc_q<=redirect_pc, → REQ.
    - Else out_ready → → REQ.
    - Else hold all outputs stable.
- Output register fields are stable whenever out_valid=1 and out_ready=0.
- Latency: request issued the cycle after entering REQ. Response accepted in cycle N → out_valid in N+1. Best-case throughput is one instruction per 3 cycles with 1-cycle memory.
- Width rules:
  - pc+4 wraps modulo 2^ADDR_W: pc 64'hFFFF_FFFF_FFFF_FFFC → next pc 0.
  - redirect_pc[1:0] are cleared on load.
- Redirect has priority over every other event in every state.

Optional Feature:
- FETCH_CTRL_COMMIT_EN defined: adds three outputs.
  - commit_valid (1), pulses for exactly the cycles with out_valid & out_ready.
  - commit_pc (ADDR_W) and commit_instr (32), equal to out_pc and out_instr.
- Used by the DPI difftest hook.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package fetch_pkg:
  - state enum (REQ, WAIT, DRAIN, HOLD).
  - DEFAULT_RESET_PC constant.
  - INSTR_W=32, PC_STEP=4.
- One sub-module, fetch_pc_gen: combinational next-pc selection. Priority is redirect (aligned) > pc+4 > hold.

Test Plan:
- Reset, then 1-cycle memory, out_ready=1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; out_instr matches memory; out_pre_pc=out_pc+4.
- out_ready=0 for 5 cycles in HOLD → out_valid stays 1, outputs stable, imem_req_valid=0, no new request.
- Redirect to 0x8000_0100 in WAIT, response 3 cycles later → response discarded, out_valid never 1 for it, next req addr 0x8000_0100.
- Redirect 0x8000_0200 then 0x8000_0300 during DRAIN → next req addr 0x8000_0300.
- Redirect same cycle as out_ready in HOLD → out_valid=0 that cycle, no transfer; redirect_pc=0x8000_0403 → req addr 0x8000_0400.
- Assert rst_n low mid-WAIT → outputs zero immediately; after release, first req addr = RESET_PC; stale response ignored (drive none).
